// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage pipeline.
// It produces the PC enable and the per-stage enable/flush controls.
module pipe_ctrl #(
    parameter int RESET_HOLD  = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_use,
    input  logic             jump_pred_miss,
    input  logic             jump_pred_adr_miss,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             halt_wb,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             flush_memwb,
    output logic             flushed,
    output logic             is_halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_INIT, S_RUN, S_MEMWAIT, S_HALT
    } state_t;

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam state_t RST_STATE = (RESET_HOLD == 0) ? S_RUN : S_INIT;

    state_t state, state_nxt;

    logic [HOLD_W-1:0] hold_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_nxt;
    logic              active;
    logic              mem_wait;
    logic              miss;
    logic              timeout;
    logic              hold_done;
    logic              stall_inc;

    assign active    = (state == S_RUN) || (state == S_MEMWAIT);
    assign mem_wait  = mem_req && !mem_ack;
    assign miss      = jump_pred_miss || jump_pred_adr_miss;
    assign wait_nxt  = wait_q + WAIT_W'(1);
    // wait_nxt is the wait_cnt value of the current cycle when it is a wait cycle
    assign timeout   = active && mem_wait && (32'(wait_nxt) == MEM_TIMEOUT);
    assign hold_done = (32'(hold_q) + 32'd1) >= 32'(RESET_HOLD);
    // halt overrides stalls; a miss overrides load_use
    assign stall_inc = active && !halt_wb &&
                       (mem_wait || (load_use && !miss));

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RST_STATE;
        else        state <= state_nxt;
    end

    // next-state decision
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT: if (hold_done) state_nxt = S_RUN;
            S_RUN, S_MEMWAIT: begin
                if (halt_wb || timeout) state_nxt = S_HALT;
                else if (mem_wait)      state_nxt = S_MEMWAIT;
                else                    state_nxt = S_RUN;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = RST_STATE;
        endcase
    end

    // Mealy stage controls
    always_comb begin
        en_pc       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exmem    = 1'b0;
        en_memwb    = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        flush_memwb = 1'b0;
        flushed     = 1'b0;
        is_halt     = 1'b0;
        unique case (state)
            S_INIT: begin
                {en_ifid, en_idex, en_exmem, en_memwb} = 4'hf;
                {flush_ifid, flush_idex, flush_exmem, flush_memwb} = 4'hf;
                flushed = 1'b1;
            end
            S_RUN, S_MEMWAIT: begin
                if (halt_wb) begin
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'hf;
                    {flush_ifid, flush_idex, flush_exmem, flush_memwb} = 4'hf;
                end else if (mem_wait) begin
                    en_memwb    = 1'b1;
                    flush_memwb = 1'b1;
                end else if (miss) begin
                    en_pc = 1'b1;
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'hf;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (load_use) begin
                    en_idex    = 1'b1;
                    en_exmem   = 1'b1;
                    en_memwb   = 1'b1;
                    flush_idex = 1'b1;
                end else begin
                    en_pc = 1'b1;
                    {en_ifid, en_idex, en_exmem, en_memwb} = 4'hf;
                end
            end
            S_HALT: begin
                is_halt = 1'b1;
                flushed = 1'b1;
            end
            default: flushed = 1'b1;
        endcase
    end

    // post-reset hold counter and consecutive memory-wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            wait_q <= '0;
        end else begin
            if (state == S_INIT) hold_q <= hold_q + HOLD_W'(1);
            wait_q <= (active && mem_wait) ? wait_nxt : '0;
        end
    end

    // sticky timeout flag and saturating stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (timeout) mem_err <= 1'b1;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl.
// Runs with RESET_HOLD=2, MEM_TIMEOUT=4, CNT_W=4.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_use = 1'b0;
    logic       jump_pred_miss = 1'b0;
    logic       jump_pred_adr_miss = 1'b0;
    logic       mem_req = 1'b0;
    logic       mem_ack = 1'b0;
    logic       halt_wb = 1'b0;
    logic       en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic       flushed, is_halt, mem_err;
    logic [3:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    wire [4:0] en = {en_pc, en_ifid, en_idex, en_exmem, en_memwb};
    wire [3:0] fl = {flush_ifid, flush_idex, flush_exmem, flush_memwb};

    pipe_ctrl #(
        .RESET_HOLD(2),
        .MEM_TIMEOUT(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_use(load_use),
        .jump_pred_miss(jump_pred_miss),
        .jump_pred_adr_miss(jump_pred_adr_miss),
        .mem_req(mem_req),
        .mem_ack(mem_ack),
        .halt_wb(halt_wb),
        .en_pc(en_pc),
        .en_ifid(en_ifid),
        .en_idex(en_idex),
        .en_exmem(en_exmem),
        .en_memwb(en_memwb),
        .flush_ifid(flush_ifid),
        .flush_idex(flush_idex),
        .flush_exmem(flush_exmem),
        .flush_memwb(flush_memwb),
        .flushed(flushed),
        .is_halt(is_halt),
        .mem_err(mem_err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // inputs: load_use, miss, adr_miss, mem_req, mem_ack, halt_wb
    task automatic drive(input logic [5:0] v);
        {load_use, jump_pred_miss, jump_pred_adr_miss,
         mem_req, mem_ack, halt_wb} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves the DUT in RUN at posedge+1
    task automatic do_reset();
        drive(6'b0);
        reset = 1'b0;
        #10;
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        drive(6'b0);
        reset = 1'b0;
        #12;
        checks++;
        if ({en, fl, flushed, is_halt, mem_err} !== {5'b01111, 4'hf, 3'b100}
            || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_vals: en=%b fl=%b fd=%b h=%b e=%b sc=%0d",
                     en, fl, flushed, is_halt, mem_err, stall_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (flushed !== 1'b1 || en_pc !== 1'b0) begin
            errors++;
            $display("FAIL hold_cyc1: flushed=%b en_pc=%b want 1 0",
                     flushed, en_pc);
        end
        tick();
        checks++;
        if (flushed !== 1'b1 || en_pc !== 1'b0) begin
            errors++;
            $display("FAIL hold_cyc2: flushed=%b en_pc=%b want 1 0",
                     flushed, en_pc);
        end
        tick();
        checks++;
        if (en !== 5'b11111 || fl !== 4'h0 || flushed !== 1'b0) begin
            errors++;
            $display("FAIL run_cyc3: en=%b fl=%b fd=%b want 11111 0000 0",
                     en, fl, flushed);
        end
    endtask

    task automatic test_load_use();
        drive(6'b100000);
        #3;
        checks++;
        if (en !== 5'b00111 || fl !== 4'b0100) begin
            errors++;
            $display("FAIL load_use: en=%b fl=%b want 00111 0100", en, fl);
        end
        tick();
        drive(6'b0);
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_stall: stall_cnt=%0d want 1", stall_cnt);
        end
    endtask

    task automatic test_miss();
        drive(6'b110000);
        #3;
        checks++;
        if (en !== 5'b11111 || fl !== 4'b1100) begin
            errors++;
            $display("FAIL miss_lu: en=%b fl=%b want 11111 1100", en, fl);
        end
        tick();
        drive(6'b001000);
        #3;
        checks++;
        if (en !== 5'b11111 || fl !== 4'b1100 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL adr_miss: en=%b fl=%b sc=%0d want 11111 1100 1",
                     en, fl, stall_cnt);
        end
        tick();
        drive(6'b0);
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            drive(6'b000100);
            #3;
            checks++;
            if (en !== 5'b00001 || fl !== 4'b0001) begin
                errors++;
                $display("FAIL memwait_%0d: en=%b fl=%b want 00001 0001",
                         i, en, fl);
            end
            tick();
        end
        drive(6'b000110);
        #3;
        checks++;
        if (en !== 5'b11111 || fl !== 4'h0) begin
            errors++;
            $display("FAIL mem_ack: en=%b fl=%b want 11111 0000", en, fl);
        end
        tick();
        drive(6'b0);
        checks++;
        if (stall_cnt !== 4'd4 || mem_err !== 1'b0 || is_halt !== 1'b0) begin
            errors++;
            $display("FAIL memwait_end: sc=%0d err=%b h=%b want 4 0 0",
                     stall_cnt, mem_err, is_halt);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) begin
            drive(6'b000100);
            #3;
            checks++;
            if (en !== 5'b00001 || is_halt !== 1'b0) begin
                errors++;
                $display("FAIL to_wait_%0d: en=%b h=%b want 00001 0",
                         i, en, is_halt);
            end
            tick();
        end
        checks++;
        if ({is_halt, mem_err, flushed} !== 3'b111 || en !== 5'b0
            || fl !== 4'h0 || stall_cnt !== 4'd8) begin
            errors++;
            $display("FAIL timeout: h=%b e=%b fd=%b en=%b fl=%b sc=%0d",
                     is_halt, mem_err, flushed, en, fl, stall_cnt);
        end
        drive(6'b000110);
        tick();
        tick();
        checks++;
        if (is_halt !== 1'b1 || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: h=%b e=%b want 1 1",
                     is_halt, mem_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({is_halt, mem_err, flushed} !== 3'b001 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL timeout_rst: h=%b e=%b fd=%b sc=%0d want 0 0 1 0",
                     is_halt, mem_err, flushed, stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_timeout_halt();
        for (int i = 0; i < 3; i++) begin
            drive(6'b000100);
            tick();
        end
        drive(6'b000101);
        #3;
        checks++;
        if (en !== 5'b01111 || fl !== 4'hf) begin
            errors++;
            $display("FAIL to_halt_cyc: en=%b fl=%b want 01111 1111", en, fl);
        end
        tick();
        drive(6'b0);
        checks++;
        if (is_halt !== 1'b1 || mem_err !== 1'b1 || stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL to_halt: h=%b e=%b sc=%0d want 1 1 3",
                     is_halt, mem_err, stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_halt();
        drive(6'b110101);
        #3;
        checks++;
        if (en !== 5'b01111 || fl !== 4'hf || is_halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_flush: en=%b fl=%b h=%b want 01111 1111 0",
                     en, fl, is_halt);
        end
        tick();
        drive(6'b0);
        checks++;
        if (en !== 5'b0 || fl !== 4'h0 || flushed !== 1'b1
            || is_halt !== 1'b1 || mem_err !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL halt_state: en=%b fl=%b fd=%b h=%b e=%b sc=%0d",
                     en, fl, flushed, is_halt, mem_err, stall_cnt);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (en !== 5'b01111 || fl !== 4'hf || is_halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_rst: en=%b fl=%b h=%b want 01111 1111 0",
                     en, fl, is_halt);
        end
        do_reset();
        checks++;
        if (en !== 5'b11111 || is_halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_rerun: en=%b h=%b want 11111 0", en, is_halt);
        end
    endtask

    task automatic test_saturate();
        drive(6'b100000);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (stall_cnt !== 4'd14) begin
            errors++;
            $display("FAIL sat_14: stall_cnt=%0d want 14", stall_cnt);
        end
        for (int i = 0; i < 6; i++) tick();
        drive(6'b0);
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_20: stall_cnt=%0d want 15", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_miss();
        test_mem_wait();
        test_timeout();
        test_timeout_halt();
        test_halt();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
